// File: rtl/sub_bytes_iter.sv
// -----------------------------------------------------------------------------
// sub_bytes_iter : iterative AES SubBytes engine.
//
// A 128-bit state is accepted over a valid/ready handshake. LANES bytes are
// pushed through S-box lanes per BUSY cycle. The finished state is then held
// on out_state with out_valid high until the consumer takes it.
//
// Parameters:
//   LANES      bytes substituted per BUSY cycle. Must be 1, 2, 4, 8 or 16.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   in_valid     input state is valid
//   in_ready     engine idle, can accept a state
//   in_state     [0:127] input state; byte k = in_state[8k +: 8], byte 0 = MSB byte
//   inverse      (only with SUB_BYTES_ITER_INV_EN) 1 = inverse S-box for this op
//   out_valid    out_state holds a completed result
//   out_ready    consumer takes out_state
//   out_state    [0:127] substituted state, same byte order as in_state
//   busy         substitution in progress
//
// Build option:
//   SUB_BYTES_ITER_INV_EN  adds the inverse port and the inverse S-box path.
// -----------------------------------------------------------------------------

// One S-box lane. The forward table is a ROM. The inverse path is built from
// GF(2^8) arithmetic: inverse affine map, then multiplicative inverse.
module sub_bytes_iter_lane (
`ifdef SUB_BYTES_ITER_INV_EN
  input  logic       inv,
`endif
  input  logic [7:0] din,
  output logic [7:0] dout
);
  // Entry 0 sits in the top byte, so entry d starts at bit 2047-8d = {~d,3'b111}.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] fwd;
  assign fwd = SBOX_FWD[{~din, 3'b111} -: 8];

`ifdef SUB_BYTES_ITER_INV_EN
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128. This maps 0 to 0, which is what the table expects.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] aff;
  // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  assign aff  = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
  assign dout = inv ? gf_inv(aff) : fwd;
`else
  assign dout = fwd;
`endif
endmodule

module sub_bytes_iter #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
`ifdef SUB_BYTES_ITER_INV_EN
  input  logic         inverse,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
);
  localparam int NCHUNK = 16 / LANES;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [0:127]    work_q, work_d;   // captured input, read-only during BUSY
  logic [0:127]    out_q, out_d;     // result register, written only in BUSY
`ifdef SUB_BYTES_ITER_INV_EN
  logic            inv_q, inv_d;
`endif

  logic                  last;
  logic [LANES-1:0][7:0] lane_out;

  assign last = (cnt_q == CW'(NCHUNK - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sub_bytes_iter_lane u_lane (
`ifdef SUB_BYTES_ITER_INV_EN
      .inv  (inv_q),
`endif
      .din  (work_q[(int'(cnt_q) * LANES + l) * 8 +: 8]),
      .dout (lane_out[l])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs decoded straight from the state, so reset clears them immediately.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      BUSY:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_state = out_q;

  // Datapath next-state logic.
  always_comb begin
    work_d = work_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
`ifdef SUB_BYTES_ITER_INV_EN
    inv_d  = inv_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        work_d = in_state;
        cnt_d  = '0;
`ifdef SUB_BYTES_ITER_INV_EN
        inv_d  = inverse;
`endif
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++)
          out_d[(int'(cnt_q) * LANES + l) * 8 +: 8] = lane_out[l];
        cnt_d = last ? '0 : cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      work_q <= '0;
      out_q  <= '0;
`ifdef SUB_BYTES_ITER_INV_EN
      inv_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      work_q <= work_d;
      out_q  <= out_d;
`ifdef SUB_BYTES_ITER_INV_EN
      inv_q  <= inv_d;
`endif
    end
  end
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: one instance per legal LANES value (1..16).
// Randomised states are checked against an S-box derived from GF(2^8) math.
module tb_sub_bytes_iter;
  localparam int ND = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid  [ND];
  logic         in_ready  [ND];
  logic [0:127] in_state  [ND];
  logic         out_valid [ND];
  logic         out_ready [ND];
  logic [0:127] out_state [ND];
  logic         busy      [ND];
`ifdef SUB_BYTES_ITER_INV_EN
  logic         inverse   [ND];
`endif

  for (genvar g = 0; g < ND; g++) begin : g_dut
    sub_bytes_iter #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
`ifdef SUB_BYTES_ITER_INV_EN
      .inverse   (inverse[g]),
`endif
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: S-box built from multiplicative inverse plus affine map.
  logic [7:0] fwd [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] t;
    t = (v << n) | (v >> (8 - n));
    return t;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fwd[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[fwd[x]] = 8'(x);
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      b = s[127 - 8*k -: 8];
      r[127 - 8*k -: 8] = inv ? isb[b] : fwd[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic scramble(input int i);
    in_valid[i] = 1'($urandom);
    in_state[i] = rnd128();
`ifdef SUB_BYTES_ITER_INV_EN
    inverse[i]  = 1'($urandom);
`endif
  endtask

  // One complete transaction on instance i: accept, latency, hold, release.
  task automatic run_op(input int i, input logic [127:0] st, input logic [127:0] exp, input int hold);
    int n, e;
    n = 16 >> i;
    e = 0;
    while (!in_ready[i] && e < 50) begin @(negedge clk); e++; end
    chk($sformatf("d%0d_ready_wait", i), in_ready[i], 1'b1);
    in_valid[i] = 1'b1;
    in_state[i] = st;
    @(posedge clk); @(negedge clk);
    e = 0;
    while (!out_valid[i] && e < 40) begin
      chk($sformatf("d%0d_busy_rdy", i), {in_ready[i], busy[i]}, 2'b01);
      scramble(i);
      @(posedge clk); @(negedge clk);
      e++;
    end
    chk($sformatf("d%0d_latency", i), e, n);
    chk($sformatf("d%0d_out_valid", i), out_valid[i], 1'b1);
    chk($sformatf("d%0d_out_state", i), out_state[i], exp);
    repeat (hold) begin
      scramble(i);
      @(posedge clk); @(negedge clk);
      chk($sformatf("d%0d_hold_flags", i), {out_valid[i], in_ready[i], busy[i]}, 3'b100);
      chk($sformatf("d%0d_hold_state", i), out_state[i], exp);
    end
    out_ready[i] = 1'b1;
    in_valid[i]  = 1'b1;
    in_state[i]  = rnd128();
    @(posedge clk); @(negedge clk);
    chk($sformatf("d%0d_release_flags", i), {out_valid[i], in_ready[i], busy[i]}, 3'b010);
    chk($sformatf("d%0d_release_state", i), out_state[i], exp);
    out_ready[i] = 1'b0;
    in_valid[i]  = 1'b0;
    @(posedge clk); @(negedge clk);
    chk($sformatf("d%0d_idle_after", i), {in_ready[i], busy[i]}, 2'b10);
    chk($sformatf("d%0d_keep_state", i), out_state[i], exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] appb_in, appb_out, bnd_in, bnd_out, st;
    bit inv;
    appb_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    appb_out = 128'hd42711aee0bf98f1b8b45de51e415230;
    bnd_in   = {4{32'h00ff0153}};
    bnd_out  = {4{32'h63167ced}};
    for (int i = 0; i < ND; i++) begin
      in_valid[i] = 1'b0; in_state[i] = '0; out_ready[i] = 1'b0;
`ifdef SUB_BYTES_ITER_INV_EN
      inverse[i] = 1'b0;
`endif
    end
    build_tables();

    repeat (3) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("d%0d_rst_flags", i), {in_ready[i], out_valid[i], busy[i]}, 3'b100);
      chk($sformatf("d%0d_rst_state", i), out_state[i], 128'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 128'h0, {16{8'h63}}, 2);
    for (int i = 0; i < ND; i++) begin
      run_op(i, appb_in, appb_out, i);
      run_op(i, bnd_in, bnd_out, (i == 0) ? 20 : 1);
      repeat (6) begin
        st  = rnd128();
        inv = 1'b0;
`ifdef SUB_BYTES_ITER_INV_EN
        inv = 1'($urandom);
        inverse[i] = inv;
`endif
        run_op(i, st, ref_sub(st, inv), $urandom_range(0, 5));
      end
`ifdef SUB_BYTES_ITER_INV_EN
      inverse[i] = 1'b1;
      run_op(i, appb_out, appb_in, 1);
      inverse[i] = 1'b1;
      run_op(i, {16{8'h63}}, 128'h0, 0);
      inverse[i] = 1'b0;
`endif
    end

    // Reset in the middle of a LANES=1 operation.
    in_valid[0] = 1'b1;
    in_state[0] = rnd128();
    @(posedge clk); @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("d%0d_midrst_flags", i), {in_ready[i], out_valid[i], busy[i]}, 3'b100);
      chk($sformatf("d%0d_midrst_state", i), out_state[i], 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, 128'h0, {16{8'h63}}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
